// File: rtl/sd_loop_filter.sv
// sd_loop_filter
//   Parametrised sigma-delta bitstream loop filter: a STAGES-deep chain of
//   integrator stages feeding a 1-bit quantiser. Coefficients are written
//   into a shadow bank at any time and copied into the active bank on a
//   sample boundary through a small IDLE -> PEND -> SWAP handshake.
//
//   Optional feature macro: SD_LOOP_FILTER_SATURATE_EN
//     defined   : overflowing adder results clamp to +max / -min
//     undefined : overflowing adder results wrap modulo 2^WIDTH
//   ovf_flag is a sticky overflow indicator in both builds.
module sd_loop_filter #(
  parameter int WIDTH   = 24,
  parameter int STAGES  = 4,
  parameter int SHIFT_W = 3,
  parameter int ADDR_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_en,
  input  logic              bit_in,
  output logic              bit_out,
  input  logic              cfg_wr,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [WIDTH-1:0]  cfg_data,
  input  logic              cfg_commit,
  input  logic              cfg_clear,
  output logic              cfg_busy,
  output logic              ovf_flag
);

  // Adders run two bits wider than the datapath so that three-term sums
  // never lose their true value before the range check.
  localparam int XW = WIDTH + 2;

  localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef SD_LOOP_FILTER_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  // Fixed config-bank addresses above the per-stage ranges.
  localparam logic [ADDR_W-1:0] ADDR_FF_OUT  = ADDR_W'(2*STAGES);
  localparam logic [ADDR_W-1:0] ADDR_SD_INIT = ADDR_W'(4*STAGES + 1);
  localparam logic [ADDR_W-1:0] ADDR_SD_FS   = ADDR_W'(4*STAGES + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SWAP = 2'd2
  } cfgState_e;

  cfgState_e state_q, state_d;
  logic      clr_q;

  // Shadow bank: written by the config port, never read by the datapath.
  logic signed [WIDTH-1:0]   ffShadow_q    [STAGES+1];
  logic signed [WIDTH-1:0]   fbShadow_q    [STAGES];
  logic        [SHIFT_W-1:0] shiftShadow_q [STAGES];
  logic signed [WIDTH-1:0]   initShadow_q  [STAGES];
  logic signed [WIDTH-1:0]   sdInitShadow_q;
  logic signed [WIDTH-1:0]   sdFsShadow_q;

  // Active bank: only ever loaded from the shadow bank during SWAP.
  logic signed [WIDTH-1:0]   ffActive_q    [STAGES+1];
  logic signed [WIDTH-1:0]   fbActive_q    [STAGES];
  logic        [SHIFT_W-1:0] shiftActive_q [STAGES];
  logic signed [WIDTH-1:0]   sdFsActive_q;

  // Integrator state and quantiser register.
  logic signed [WIDTH-1:0] integ_q [STAGES];
  logic signed [WIDTH-1:0] integ_d [STAGES];
  logic signed [WIDTH-1:0] sdReg_q, sdReg_d;
  logic                    ovf_q;

  // Arithmetic results of one sample step with the active bank.
  logic signed [WIDTH-1:0] integCalc [STAGES];
  logic signed [WIDTH-1:0] sdCalc;
  logic                    ovfHit;
  logic signed [XW-1:0]    acc;
  logic signed [WIDTH-1:0] gVal;
  logic signed [WIDTH-1:0] stageIn;
  logic signed [WIDTH-1:0] xVal;

  logic swapNow;
  logic clearNow;

  function automatic logic signed [XW-1:0] ext(input logic signed [WIDTH-1:0] a);
    return {{2{a[WIDTH-1]}}, a};
  endfunction

  // A bitstream bit selects between +coef and -coef.
  function automatic logic signed [XW-1:0] signedTerm(input logic pos,
                                                      input logic signed [WIDTH-1:0] a);
    return pos ? ext(a) : -ext(a);
  endfunction

  // In range exactly when the top three bits of the wide sum agree.
  function automatic logic outOfRange(input logic signed [XW-1:0] v);
    return !((&v[XW-1:WIDTH-1]) || !(|v[XW-1:WIDTH-1]));
  endfunction

  function automatic logic signed [WIDTH-1:0] fitWidth(input logic signed [XW-1:0] v);
    return (SATURATE && outOfRange(v)) ? (v[XW-1] ? MIN_V : MAX_V) : v[WIDTH-1:0];
  endfunction

  assign bit_out  = ~sdReg_q[WIDTH-1];
  assign cfg_busy = (state_q != IDLE);
  assign ovf_flag = ovf_q;
  assign swapNow  = (state_q == SWAP);
  assign clearNow = swapNow && clr_q;

  // Config handshake state register; a commit's clear request is captured
  // only when the commit is accepted in IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cfg_commit) begin
        clr_q <= cfg_clear;
      end
    end
  end

  // Next-state logic: commits outside IDLE are dropped, PEND waits for the
  // next sample strobe, SWAP lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_commit) state_d = PEND;
      PEND:    if (sample_en)  state_d = SWAP;
      SWAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shadow bank writes; addresses past the map are silently ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= STAGES; k++) begin
        ffShadow_q[k] <= '0;
      end
      for (int k = 0; k < STAGES; k++) begin
        fbShadow_q[k]    <= '0;
        shiftShadow_q[k] <= '0;
        initShadow_q[k]  <= '0;
      end
      sdInitShadow_q <= '0;
      sdFsShadow_q   <= '0;
    end else if (cfg_wr) begin
      for (int k = 0; k < STAGES; k++) begin
        if (cfg_addr == ADDR_W'(k))              ffShadow_q[k]    <= cfg_data;
        if (cfg_addr == ADDR_W'(STAGES + k))     fbShadow_q[k]    <= cfg_data;
        if (cfg_addr == ADDR_W'(2*STAGES+1 + k)) shiftShadow_q[k] <= cfg_data[SHIFT_W-1:0];
        if (cfg_addr == ADDR_W'(3*STAGES+1 + k)) initShadow_q[k]  <= cfg_data;
      end
      if (cfg_addr == ADDR_FF_OUT)  ffShadow_q[STAGES] <= cfg_data;
      if (cfg_addr == ADDR_SD_INIT) sdInitShadow_q     <= cfg_data;
      if (cfg_addr == ADDR_SD_FS)   sdFsShadow_q       <= cfg_data;
    end
  end

  // Atomic bank swap; the copy sees the shadow contents from before any
  // write landing in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= STAGES; k++) begin
        ffActive_q[k] <= '0;
      end
      for (int k = 0; k < STAGES; k++) begin
        fbActive_q[k]    <= '0;
        shiftActive_q[k] <= '0;
      end
      sdFsActive_q <= '0;
    end else if (swapNow) begin
      for (int k = 0; k <= STAGES; k++) begin
        ffActive_q[k] <= ffShadow_q[k];
      end
      for (int k = 0; k < STAGES; k++) begin
        fbActive_q[k]    <= fbShadow_q[k];
        shiftActive_q[k] <= shiftShadow_q[k];
      end
      sdFsActive_q <= sdFsShadow_q;
    end
  end

  // One sample step of the integrator chain and quantiser using the active
  // bank; each stage sees the previous stage's registered, shifted output.
  always_comb begin
    ovfHit  = 1'b0;
    acc     = '0;
    gVal    = '0;
    xVal    = '0;
    stageIn = '0;
    for (int k = 0; k < STAGES; k++) begin
      acc          = signedTerm(bit_in, ffActive_q[k]) - signedTerm(bit_out, fbActive_q[k])
                     + ext(stageIn);
      ovfHit       = ovfHit | outOfRange(acc);
      gVal         = fitWidth(acc);
      acc          = ext(gVal) - ext(integ_q[k]);
      ovfHit       = ovfHit | outOfRange(acc);
      integCalc[k] = fitWidth(acc);
      stageIn      = integ_q[k] >>> shiftActive_q[k];
    end
    acc    = signedTerm(bit_in, ffActive_q[STAGES]) + ext(stageIn);
    ovfHit = ovfHit | outOfRange(acc);
    xVal   = fitWidth(acc);
    acc    = ext(xVal) - signedTerm(bit_out, sdFsActive_q) - ext(sdReg_q);
    ovfHit = ovfHit | outOfRange(acc);
    sdCalc = fitWidth(acc);
  end

  // Select the next integrator contents: a clearing swap loads the init
  // values and wins over a simultaneous sample step; otherwise hold unless
  // the sample strobe is high.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      integ_d[k] = integ_q[k];
    end
    sdReg_d = sdReg_q;
    if (clearNow) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_d[k] = initShadow_q[k];
      end
      sdReg_d = sdInitShadow_q;
    end else if (sample_en) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_d[k] = integCalc[k];
      end
      sdReg_d = sdCalc;
    end
  end

  // Integrator registers and the sticky overflow flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= '0;
      end
      sdReg_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= integ_d[k];
      end
      sdReg_q <= sdReg_d;
      if (sample_en && ovfHit) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule
